// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame geometry,
// common keyboard command bytes and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_XFER,
        ST_WAIT_IDLE,
        ST_FINISH
    } ps2_tx_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_BIT_CNT_W  = 4;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

    // Odd parity: total number of ones across data and parity is odd.
    function automatic logic ps2_odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line plus a falling-edge strobe.
// Every stage resets high (idle line), so reset release never yields an edge.
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic line_in,
    output logic line_sync,
    output logic fall_c
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = line_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign line_sync = sync_q;
    // Only a synced 1->0 transition strobes; a held-low line does not.
    assign fall_c    = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, bit shifting on
// device clock falling edges, ACK check, and a watchdog over the device phase.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned INHIBIT_CYCLES = (CLK_FREQ_HZ / 1_000_000) * 120,
    parameter int unsigned TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1_000) * 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [INH_W-1:0]         INH_LAST    = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]          WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PS2_BIT_CNT_W-1:0] PARITY_EDGE = PS2_BIT_CNT_W'(8);
    localparam logic [PS2_BIT_CNT_W-1:0] STOP_EDGE   = PS2_BIT_CNT_W'(9);
    localparam logic [PS2_BIT_CNT_W-1:0] ACK_EDGE    = PS2_BIT_CNT_W'(PS2_FRAME_BITS - 1);

    logic clk_sync, clk_fall;
    logic dat_sync, dat_fall_unused;

    ps2_line_sync u_clk_sync (
        .clock     (clock),
        .reset     (reset),
        .line_in   (ps2_clk_in),
        .line_sync (clk_sync),
        .fall_c    (clk_fall)
    );

    ps2_line_sync u_dat_sync (
        .clock     (clock),
        .reset     (reset),
        .line_in   (ps2_dat_in),
        .line_sync (dat_sync),
        .fall_c    (dat_fall_unused)
    );

    ps2_tx_state_e            state_q, state_d;
    logic [7:0]               data_q, data_d;
    logic                     par_q, par_d;
    logic                     nack_q, nack_d;
    logic [PS2_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0]         inh_cnt_q, inh_cnt_d;
    logic [WD_W-1:0]          wd_cnt_q, wd_cnt_d;
    logic                     clk_oe_q, clk_oe_d;
    logic                     dat_oe_q, dat_oe_d;
    logic                     tx_ready_q, tx_ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_d     = par_q;
        nack_d    = nack_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        wd_cnt_d  = wd_cnt_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid && tx_ready_q) begin
                    data_d    = tx_data;
                    par_d     = ps2_odd_parity(tx_data);
                    nack_d    = 1'b0;
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    dat_oe_d = 1'b1;
                    state_d  = ST_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end

            // Release the clock while data stays low as the start bit.
            ST_REQ: begin
                clk_oe_d  = 1'b0;
                wd_cnt_d  = '0;
                bit_cnt_d = '0;
                state_d   = ST_XFER;
            end

            ST_XFER: begin
                if (wd_cnt_q == WD_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                    if (clk_fall) begin
                        bit_cnt_d = bit_cnt_q + PS2_BIT_CNT_W'(1);
                        if (bit_cnt_q < PARITY_EDGE) begin
                            dat_oe_d = ~data_q[bit_cnt_q[2:0]];
                        end else if (bit_cnt_q == PARITY_EDGE) begin
                            dat_oe_d = ~par_q;
                        end else if (bit_cnt_q == STOP_EDGE) begin
                            dat_oe_d = 1'b0;
                        end else if (bit_cnt_q == ACK_EDGE) begin
                            nack_d   = dat_sync;
                            dat_oe_d = 1'b0;
                            state_d  = ST_WAIT_IDLE;
                        end
                    end
                end
            end

            ST_WAIT_IDLE: begin
                if (wd_cnt_q == WD_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                    if (clk_sync && dat_sync) begin
                        done_d  = 1'b1;
                        error_d = nack_q;
                        state_d = ST_FINISH;
                    end
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        tx_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            par_q      <= 1'b0;
            nack_q     <= 1'b0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            wd_cnt_q   <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            par_q      <= par_d;
            nack_q     <= nack_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            wd_cnt_q   <= wd_cnt_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign tx_ready   = tx_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
